// File: rtl/async_pkg.sv
// -----------------------------------------------------------------------------
// async_pkg
// Shared definitions for the parameterised synchronous FIFO:
//   fifo_mode_e   - read-port behaviour (STANDARD registered read, FWFT)
//   params_legal  - elaboration-time legality check of the FIFO parameters
// -----------------------------------------------------------------------------
package async_pkg;

  typedef enum logic {
    STANDARD = 1'b0,
    FWFT     = 1'b1
  } fifo_mode_e;

  // True when the parameter set describes a buildable FIFO. The thresholds
  // must leave almost_empty strictly below almost_full so both flags can never
  // describe the same occupancy.
  function automatic bit params_legal(input int width, input int addrwidth,
                                      input int fwft, input int afull_th,
                                      input int aempty_th);
    int depth;
    depth = 1 << addrwidth;
    return (width >= 1) && (width <= 64) &&
           (addrwidth >= 2) && (addrwidth <= 12) &&
           ((fwft == 0) || (fwft == 1)) &&
           (afull_th >= 1) && (afull_th <= depth - 1) &&
           (aempty_th >= 0) && (aempty_th <= depth - 2) &&
           (aempty_th < afull_th);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Handshake/data bundle of the synchronous FIFO.
//   master : producer/consumer side (drives wr, datain, rd, clr_err)
//   slave  : FIFO side (drives dataout, status flags, count, error flags)
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int WIDTH     = 8,
  parameter int ADDRWIDTH = 3
);

  logic                 wr;
  logic [WIDTH-1:0]     datain;
  logic                 rd;
  logic                 clr_err;
  logic [WIDTH-1:0]     dataout;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDRWIDTH:0]   count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr, datain, rd, clr_err,
    input  dataout, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr, datain, rd, clr_err,
    output dataout, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage, one clock, registered read (block-RAM style).
//   clk    - clock
//   reset  - synchronous active-high clear of the read data register only
//   we     - write enable; waddr/wdata written on the rising edge
//   re     - read enable; rdata <= mem[raddr] on the rising edge, else holds
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int WIDTH     = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset; a reset port would stop the tools
  // mapping it onto block RAM, and stale words are never exposed anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-during-write to the same address returns the old word; the FIFO top
  // covers that case with its own bypass register.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parameterised synchronous FIFO with optional first-word-fall-through read.
//   clk    - sole clock, rising edge
//   reset  - synchronous active-high reset (contents discarded in one cycle)
//   bus    - sync_fifo_param_if.slave: wr/datain, rd/dataout, full, empty,
//            almost_full, almost_empty, count, sticky overflow/underflow,
//            clr_err
// Parameters: WIDTH, ADDRWIDTH (DEPTH = 2**ADDRWIDTH), FWFT (0/1),
//             AFULL_TH, AEMPTY_TH.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int ADDRWIDTH = 3,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = (1 << ADDRWIDTH) - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sync_fifo_param_if.slave      bus
);

  typedef logic [ADDRWIDTH:0] ptr_t;

  localparam ptr_t DEPTH_LVL  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam ptr_t AFULL_LVL  = AFULL_TH[ADDRWIDTH:0];
  localparam ptr_t AEMPTY_LVL = AEMPTY_TH[ADDRWIDTH:0];
  localparam async_pkg::fifo_mode_e MODE =
    (FWFT == 1) ? async_pkg::FWFT : async_pkg::STANDARD;

  if (!async_pkg::params_legal(WIDTH, ADDRWIDTH, FWFT, AFULL_TH, AEMPTY_TH))
  begin : g_bad_params
    $error("sync_fifo_param: illegal parameter combination");
  end

  // Pointers carry one wrap bit above the storage address.
  ptr_t             wr_ptr, rd_ptr, count;
  ptr_t             wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic             full_q, empty_q, overflow_q, underflow_q;
  logic             wr_acc, rd_acc;
  logic             mem_re;
  logic [ADDRWIDTH-1:0] mem_raddr;
  logic             byp_load, byp_valid;
  logic [WIDTH-1:0] byp_data, mem_rdata;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wr_acc     = bus.wr & ~full_q;
    rd_acc     = bus.rd & ~empty_q;
    wr_ptr_nxt = wr_ptr + ptr_t'(wr_acc);
    rd_ptr_nxt = rd_ptr + ptr_t'(rd_acc);
    count_nxt  = count + ptr_t'(wr_acc) - ptr_t'(rd_acc);
    mem_re     = rd_acc;
    mem_raddr  = rd_ptr[ADDRWIDTH-1:0];
    byp_load   = 1'b0;
    if (MODE == async_pkg::FWFT) begin
      // Prefetch the head that will exist after this edge. When the FIFO is
      // about to be empty, leave the read register alone so dataout holds.
      mem_re    = (count_nxt != '0);
      mem_raddr = rd_ptr_nxt[ADDRWIDTH-1:0];
      // The word written this edge becomes the head when nothing else is left:
      // the RAM would return the stale word, so capture datain instead.
      byp_load  = wr_acc & (count == ptr_t'(rd_acc));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_q      <= 1'b1;   // pessimistic until the first edge out of reset
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      byp_valid   <= 1'b0;
      byp_data    <= '0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full_q      <= (count_nxt == DEPTH_LVL);
      empty_q     <= (count_nxt == '0);
      // Setting wins over clearing in the same cycle.
      overflow_q  <= (overflow_q  & ~bus.clr_err) | (bus.wr & full_q);
      underflow_q <= (underflow_q & ~bus.clr_err) | (bus.rd & empty_q);
      if (mem_re) begin
        byp_valid <= byp_load;
        if (byp_load) byp_data <= bus.datain;
      end
    end
  end

  fifo_mem #(
    .WIDTH     (WIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDRWIDTH-1:0]),
    .wdata (bus.datain),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign bus.dataout      = byp_valid ? byp_data : mem_rdata;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AFULL_LVL);
  assign bus.almost_empty = (count <= AEMPTY_LVL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Occupancy register and pointer difference must always agree.
  ptr_count_consistent: assert property (
    @(posedge clk) disable iff (reset) count == (wr_ptr - rd_ptr)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// dut_a: default parameters (8 x 8, standard read), directed vectors.
// dut_b: WIDTH=32, ADDRWIDTH=5, FWFT=1, directed start then random traffic
//        against a reference queue.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic clk;
  logic reset_a, reset_b;
  int   n_checks = 0;
  int   n_pass   = 0;

  sync_fifo_param_if #(.WIDTH(8),  .ADDRWIDTH(3)) bus_a ();
  sync_fifo_param_if #(.WIDTH(32), .ADDRWIDTH(5)) bus_b ();

  sync_fifo_param dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  sync_fifo_param #(.WIDTH(32), .ADDRWIDTH(5), .FWFT(1)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic w, input logic r, input logic c,
                         input logic [7:0] d);
    bus_a.wr = w; bus_a.rd = r; bus_a.clr_err = c; bus_a.datain = d;
  endtask

  // Reference model for dut_b (registered flags mirror the FIFO's view).
  logic [31:0] mq[$];
  logic [31:0] m_last;
  bit          m_full, m_empty, m_ovf, m_unf;

  task automatic b_cycle(input logic w, input logic r, input logic c,
                         input logic [31:0] d);
    bit wacc, racc;
    bus_b.wr = w; bus_b.rd = r; bus_b.clr_err = c; bus_b.datain = d;
    wacc  = w && !m_full;
    racc  = r && !m_empty;
    m_ovf = (m_ovf && !c) || (w && m_full);
    m_unf = (m_unf && !c) || (r && m_empty);
    tick();
    if (racc) m_last = mq.pop_front();
    if (wacc) mq.push_back(d);
    m_full  = (mq.size() == 32);
    m_empty = (mq.size() == 0);
    check("b_count",  bus_b.count, 64'(mq.size()));
    check("b_empty",  bus_b.empty, m_empty);
    check("b_full",   bus_b.full,  m_full);
    check("b_afull",  bus_b.almost_full,  mq.size() >= 30);
    check("b_aempty", bus_b.almost_empty, mq.size() <= 1);
    check("b_ovf",    bus_b.overflow,  m_ovf);
    check("b_unf",    bus_b.underflow, m_unf);
    check("b_dout",   bus_b.dataout, m_empty ? m_last : mq[0]);
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    drive_a(0, 0, 0, 8'h00);
    bus_b.wr = 0; bus_b.rd = 0; bus_b.clr_err = 0; bus_b.datain = '0;

    // ---------------- dut_a: reset state ----------------
    tick(); tick();
    check("a_rst_count",  bus_a.count, 0);
    check("a_rst_empty",  bus_a.empty, 1);
    check("a_rst_full",   bus_a.full, 1);
    check("a_rst_aempty", bus_a.almost_empty, 1);
    check("a_rst_afull",  bus_a.almost_full, 0);
    check("a_rst_ovf",    bus_a.overflow, 0);
    check("a_rst_unf",    bus_a.underflow, 0);
    check("a_rst_dout",   bus_a.dataout, 0);
    reset_a = 1'b0;
    tick();
    check("a_full_release", bus_a.full, 0);
    check("a_empty_release", bus_a.empty, 1);

    // ---------------- fill 0x01..0x08 ----------------
    for (int i = 1; i <= 8; i++) begin
      drive_a(1, 0, 0, 8'(i));
      tick();
      check("a_fill_count",  bus_a.count, i);
      check("a_fill_full",   bus_a.full, i == 8);
      check("a_fill_afull",  bus_a.almost_full, i >= 6);
      check("a_fill_aempty", bus_a.almost_empty, i <= 1);
      check("a_fill_empty",  bus_a.empty, 0);
    end
    drive_a(1, 0, 0, 8'h09);
    tick();
    check("a_ovf_set",   bus_a.overflow, 1);
    check("a_ovf_count", bus_a.count, 8);
    check("a_ovf_dout",  bus_a.dataout, 0);

    // ---------------- drain in order ----------------
    for (int i = 1; i <= 8; i++) begin
      drive_a(0, 1, 0, 8'h00);
      tick();
      check("a_drain_dout",  bus_a.dataout, i);
      check("a_drain_count", bus_a.count, 8 - i);
      check("a_drain_empty", bus_a.empty, i == 8);
    end
    tick();
    check("a_unf_set",  bus_a.underflow, 1);
    check("a_unf_hold", bus_a.dataout, 8'h08);

    // Set and clear together: underflow stays, overflow clears.
    drive_a(0, 1, 1, 8'h00);
    tick();
    check("a_clr_setwins", bus_a.underflow, 1);
    check("a_clr_ovf",     bus_a.overflow, 0);
    drive_a(0, 0, 1, 8'h00);
    tick();
    check("a_clr_unf", bus_a.underflow, 0);

    // rd+wr while empty: write only, no bypass to dataout.
    drive_a(1, 1, 0, 8'h55);
    tick();
    check("a_re_count", bus_a.count, 1);
    check("a_re_empty", bus_a.empty, 0);
    check("a_re_dout",  bus_a.dataout, 8'h08);
    check("a_re_unf",   bus_a.underflow, 1);
    drive_a(1, 0, 1, 8'h56); tick();
    check("a_re_clr", bus_a.underflow, 0);
    drive_a(1, 0, 0, 8'h57); tick();
    drive_a(1, 0, 0, 8'h58); tick();
    check("a_cnt4", bus_a.count, 4);

    // 20 cycles of simultaneous rd/wr at count 4.
    for (int k = 0; k < 20; k++) begin
      drive_a(1, 1, 0, 8'(8'h59 + k));
      tick();
      check("a_rw_dout",  bus_a.dataout, 8'(8'h55 + k));
      check("a_rw_count", bus_a.count, 4);
    end

    // Refill to full (0x69..0x6C remain, add 0x6D..0x70).
    for (int k = 0; k < 4; k++) begin
      drive_a(1, 0, 0, 8'(8'h6D + k));
      tick();
    end
    check("a_refull", bus_a.full, 1);

    // rd+wr while full: read only, overflow set.
    drive_a(1, 1, 0, 8'hEE);
    tick();
    check("a_rf_count", bus_a.count, 7);
    check("a_rf_full",  bus_a.full, 0);
    check("a_rf_dout",  bus_a.dataout, 8'h69);
    check("a_rf_ovf",   bus_a.overflow, 1);
    drive_a(0, 1, 0, 8'h00); tick();
    check("a_rf_dout2", bus_a.dataout, 8'h6A);
    tick();
    check("a_cnt5", bus_a.count, 5);

    // Reset mid-operation with rd=wr=1.
    reset_a = 1'b1;
    drive_a(1, 1, 0, 8'hCC);
    tick();
    check("a_mr_count", bus_a.count, 0);
    check("a_mr_empty", bus_a.empty, 1);
    check("a_mr_full",  bus_a.full, 1);
    check("a_mr_ovf",   bus_a.overflow, 0);
    check("a_mr_unf",   bus_a.underflow, 0);
    check("a_mr_dout",  bus_a.dataout, 0);
    reset_a = 1'b0;
    drive_a(0, 0, 0, 8'h00);
    tick();
    check("a_mr_release", bus_a.full, 0);
    drive_a(1, 0, 0, 8'h77); tick();
    check("a_post_count", bus_a.count, 1);
    drive_a(0, 1, 0, 8'h00); tick();
    check("a_post_dout",  bus_a.dataout, 8'h77);
    check("a_post_empty", bus_a.empty, 1);
    drive_a(0, 0, 0, 8'h00);

    // ---------------- dut_b: FWFT ----------------
    check("b_rst_count", bus_b.count, 0);
    check("b_rst_full",  bus_b.full, 1);
    check("b_rst_empty", bus_b.empty, 1);
    check("b_rst_dout",  bus_b.dataout, 0);
    reset_b = 1'b0;
    m_full = 1; m_empty = 1; m_ovf = 0; m_unf = 0; m_last = '0;
    b_cycle(0, 0, 0, 32'h0);
    b_cycle(1, 0, 0, 32'hA5);
    check("b_a5_dout",  bus_b.dataout, 32'hA5);
    check("b_a5_empty", bus_b.empty, 0);
    b_cycle(0, 0, 0, 32'h0);
    b_cycle(0, 1, 0, 32'h0);
    check("b_a5_pop", bus_b.empty, 1);
    b_cycle(1, 0, 0, 32'hB0);
    b_cycle(1, 1, 0, 32'hB1);
    b_cycle(1, 1, 0, 32'hB2);
    b_cycle(0, 1, 0, 32'h0);

    // Phased random traffic so the FIFO visits full and empty repeatedly.
    for (int i = 0; i < 2400; i++) begin
      int pct;
      pct = ((i / 300) % 2 == 0) ? 85 : 20;
      b_cycle($urandom_range(0, 99) < pct,
              $urandom_range(0, 99) >= pct,
              $urandom_range(0, 99) < 2,
              $urandom);
    end
    bus_b.wr = 0; bus_b.rd = 0; bus_b.clr_err = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
